// File: rtl/sdr_pkt_pkg.sv
// Shared constants and types for the COBS packet path (encoder and streamer).
// Contents:
//   PKT_LEN_DEFAULT - bytes per encoded packet
//   COBS_DELIM      - frame delimiter byte
//   COBS_MAX_CODE   - largest COBS code byte
//   stream_state_e  - packet_streamer FSM states
package sdr_pkt_pkg;

  localparam int unsigned PKT_LEN_DEFAULT = 253;
  localparam logic [7:0]  COBS_DELIM      = 8'h00;
  localparam logic [7:0]  COBS_MAX_CODE   = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_FETCH = 3'd2,
    S_DELIM = 3'd3,
    S_DONE  = 3'd4
  } stream_state_e;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry valid/ready byte buffer with occupancy output.
// Ports:
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_wr_en        - push i_wr_data (ignored when full and not popping)
//   i_wr_data      - data to push
//   i_rd_en        - pop the head entry (ignored when empty)
//   o_rd_data      - head entry
//   o_valid        - buffer not empty
//   o_count        - number of stored entries (0..2)
module stream_skid_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_valid,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic             w_rd;
  logic             w_wr;

  assign w_rd = i_rd_en && (r_count != 2'd0);
  // A full buffer still accepts a write in the same clock as a pop.
  assign w_wr = i_wr_en && ((r_count != 2'd2) || w_rd);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= i_wr_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_rd) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_data = r_mem[r_rptr];
  assign o_valid   = (r_count != 2'd0);
  assign o_count   = r_count;

endmodule

// File: rtl/packet_streamer.sv
// Reads a finished packet out of the COBS encoder's read buffer and streams it
// on a valid/ready byte interface, optionally followed by a frame delimiter.
// Ports:
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_pkt_stb      - one-cycle pulse: a complete packet is readable
//   o_raddr        - read address to the encoder (data returns next clock)
//   i_rdata        - read data from the encoder
//   o_tdata        - stream byte
//   o_tvalid       - o_tdata valid
//   i_tready       - sink ready; transfer on o_tvalid && i_tready
//   o_tlast        - final byte of the frame
//   o_busy         - frame in progress
//   o_overrun      - sticky: a strobe arrived while busy
//   o_drop_cnt     - saturating count of dropped strobes
//   o_pkt_cnt      - wrapping count of completed frames
module packet_streamer
  import sdr_pkt_pkg::*;
#(
  parameter int unsigned PKT_LEN      = PKT_LEN_DEFAULT,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter logic [7:0]  DELIM        = COBS_DELIM,
  parameter bit          APPEND_DELIM = 1'b1,
  parameter int unsigned START_DELAY  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_pkt_stb,
  output logic [ADDR_WIDTH-1:0] o_raddr,
  input  logic [7:0]            i_rdata,
  output logic [7:0]            o_tdata,
  output logic                  o_tvalid,
  input  logic                  i_tready,
  output logic                  o_tlast,
  output logic                  o_busy,
  output logic                  o_overrun,
  output logic [7:0]            o_drop_cnt,
  output logic [15:0]           o_pkt_cnt
);

  localparam int unsigned DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY + 1) : 1;
  // One extra pointer bit so PKT_LEN = 2^ADDR_WIDTH compares without wrapping.
  localparam logic [ADDR_WIDTH:0] PTR_END = (ADDR_WIDTH + 1)'(PKT_LEN);

  stream_state_e         r_state;
  stream_state_e         w_state_nxt;
  logic [DLY_W-1:0]      r_dly;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic                  r_inflight;
  logic                  r_busy;
  logic                  r_overrun;
  logic [7:0]            r_drop_cnt;
  logic [15:0]           r_pkt_cnt;

  logic [1:0]            w_occ;
  logic                  w_buf_valid;
  logic [7:0]            w_buf_data;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_rd_done;
  logic                  w_fetch_done;
  logic                  w_head_last;
  logic [2:0]            w_pending;

  stream_skid_buf #(
    .WIDTH (8)
  ) u_skid (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (r_inflight),
    .i_wr_data (i_rdata),
    .i_rd_en   (w_pop),
    .o_rd_data (w_buf_data),
    .o_valid   (w_buf_valid),
    .o_count   (w_occ)
  );

  assign w_rd_done = (r_rd_ptr == PTR_END);
  assign w_pop     = (r_state == S_FETCH) && w_buf_valid && i_tready;
  assign w_pending = {1'b0, w_occ} + {2'b00, r_inflight};
  // The slot freed by this clock's pop counts as space, keeping the stream
  // gapless under continuous ready.
  assign w_issue   = (r_state == S_FETCH) && !w_rd_done &&
                     (w_pending < (3'd2 + {2'b00, w_pop}));
  assign w_head_last  = w_rd_done && !r_inflight && (w_occ == 2'd1);
  assign w_fetch_done = w_rd_done && !r_inflight &&
                        ((w_occ == 2'd0) || ((w_occ == 2'd1) && w_pop));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_pkt_stb) begin
          w_state_nxt = (START_DELAY == 0) ? S_FETCH : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_dly <= DLY_W'(1)) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_fetch_done) begin
          w_state_nxt = APPEND_DELIM ? S_DELIM : S_DONE;
        end
      end
      S_DELIM: begin
        if (i_tready) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_dly      <= '0;
      r_rd_ptr   <= '0;
      r_raddr    <= '0;
      r_inflight <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
      r_drop_cnt <= 8'd0;
      r_pkt_cnt  <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;

      if (r_state == S_IDLE && i_pkt_stb) begin
        r_rd_ptr <= '0;
        r_dly    <= DLY_W'(START_DELAY);
        r_busy   <= 1'b1;
      end

      if (r_state == S_WAIT) begin
        r_dly <= r_dly - DLY_W'(1);
      end

      if (w_issue) begin
        r_raddr  <= r_rd_ptr[ADDR_WIDTH-1:0];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end

      if (r_state == S_DONE) begin
        r_pkt_cnt <= r_pkt_cnt + 16'd1;
        r_busy    <= 1'b0;
      end

      // S_DONE still counts as busy for strobe rejection.
      if (i_pkt_stb && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
        if (r_drop_cnt != 8'hFF) begin
          r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end
    end
  end

  // Address is driven combinationally on issue so the first read goes out
  // START_DELAY clocks after the strobe; otherwise the last address is held.
  assign o_raddr    = w_issue ? r_rd_ptr[ADDR_WIDTH-1:0] : r_raddr;
  assign o_tvalid   = w_buf_valid || (r_state == S_DELIM);
  assign o_tdata    = (r_state == S_DELIM) ? DELIM : w_buf_data;
  assign o_tlast    = (r_state == S_DELIM) ||
                      (!APPEND_DELIM && (r_state == S_FETCH) && w_buf_valid && w_head_last);
  assign o_busy     = r_busy;
  assign o_overrun  = r_overrun;
  assign o_drop_cnt = r_drop_cnt;
  assign o_pkt_cnt  = r_pkt_cnt;

endmodule

// File: tb/tb_packet_streamer.sv
`timescale 1ns/1ps
module tb_packet_streamer;
  localparam int PLEN  = 253;
  localparam int PLEN2 = 4;

  typedef struct { logic [7:0] data; logic last; } beat_t;
  typedef struct { int pct; int pat; int span; int pkt; } row_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stb = 1'b0, rdy = 1'b0;
  logic [7:0] raddr, rdata, tdata, drop;
  logic tvalid, tlast, busy, overrun;
  logic [15:0] pkt;
  logic stb2 = 1'b0, rdy2 = 1'b1;
  logic [7:0] raddr2, rdata2, tdata2, drop2;
  logic tvalid2, tlast2, busy2, overrun2;
  logic [15:0] pkt2;

  logic [7:0] mem [256];
  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  int rdy_pct = 100, rdy_div = 0;

  beat_t q[$], q2[$];
  int n_acc = 0, n_acc2 = 0;
  int first_valid_cyc = 0, first_acc_cyc = 0, last_cyc = 0, first_valid2 = 0, strobe_cyc = 0;
  bit seen_valid = 0, seen_acc = 0, seen_valid2 = 0;
  row_t rows[4];

  packet_streamer u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pkt_stb(stb), .o_raddr(raddr), .i_rdata(rdata),
    .o_tdata(tdata), .o_tvalid(tvalid), .i_tready(rdy), .o_tlast(tlast), .o_busy(busy),
    .o_overrun(overrun), .o_drop_cnt(drop), .o_pkt_cnt(pkt)
  );

  packet_streamer #(
    .PKT_LEN(PLEN2), .ADDR_WIDTH(8), .DELIM(8'h00), .APPEND_DELIM(1'b0), .START_DELAY(2)
  ) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pkt_stb(stb2), .o_raddr(raddr2), .i_rdata(rdata2),
    .o_tdata(tdata2), .o_tvalid(tvalid2), .i_tready(rdy2), .o_tlast(tlast2), .o_busy(busy2),
    .o_overrun(overrun2), .o_drop_cnt(drop2), .o_pkt_cnt(pkt2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Encoder read-buffer model: synchronous read, data one clock after address.
  always @(posedge clk) begin
    rdata  <= mem[raddr];
    rdata2 <= mem[raddr2];
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_div > 0) rdy = ((cyc % rdy_div) == 0);
    else rdy = (int'($urandom_range(99)) < rdy_pct);
  end

  // Stream monitor / scoreboard for the default instance.
  initial begin : mon1
    bit prev_hold;
    logic [7:0] prev_data;
    logic prev_last;
    beat_t e;
    prev_hold = 0;
    prev_data = 0;
    prev_last = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 0;
      end else begin
        if (prev_hold) begin
          check("hold_valid", int'(tvalid), 1);
          check("hold_data", int'(tdata), int'(prev_data));
          check("hold_last", int'(tlast), int'(prev_last));
        end
        check("raddr_range", int'(int'(raddr) < PLEN), 1);
        if (tvalid && !seen_valid) begin
          seen_valid = 1;
          first_valid_cyc = cyc;
        end
        if (tvalid && rdy) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL extra_byte: got %0d expected no byte (cycle %0d)", tdata, cyc);
          end else begin
            e = q.pop_front();
            check("data", int'(tdata), int'(e.data));
            check("last", int'(tlast), int'(e.last));
          end
          if (!seen_acc) begin
            seen_acc = 1;
            first_acc_cyc = cyc;
          end
          n_acc++;
          if (tlast) last_cyc = cyc;
        end
        prev_hold = tvalid && !rdy;
        prev_data = tdata;
        prev_last = tlast;
      end
    end
  end

  initial begin : mon2
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (tvalid2 && !seen_valid2) begin
          seen_valid2 = 1;
          first_valid2 = cyc;
        end
        if (tvalid2 && rdy2) begin
          if (q2.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL extra_byte2: got %0d expected no byte (cycle %0d)", tdata2, cyc);
          end else begin
            e = q2.pop_front();
            check("data2", int'(tdata2), int'(e.data));
            check("last2", int'(tlast2), int'(e.last));
          end
          n_acc2++;
        end
      end
    end
  end

  task automatic fill(input int pat);
    for (int a = 0; a < 256; a++) begin
      case (pat)
        0:       mem[a] = (a == 0) ? 8'hFF : 8'(a);
        1:       mem[a] = 8'($urandom_range(255));
        default: mem[a] = 8'(a * 7 + 3);
      endcase
    end
  endtask

  task automatic start_frame(input int pat);
    fill(pat);
    for (int a = 0; a < PLEN; a++) q.push_back('{mem[a], 1'b0});
    q.push_back('{8'h00, 1'b1});
    n_acc = 0;
    seen_valid = 0;
    seen_acc = 0;
    @(posedge clk);
    #1;
    stb = 1'b1;
    strobe_cyc = cyc + 1;
    @(posedge clk);
    #1;
    stb = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input string name);
    int k;
    for (k = 0; k < 5000; k++) begin
      @(posedge clk);
      #1;
      if (!(sel ? busy2 : busy)) break;
    end
    check(name, int'(k < 5000), 1);
  endtask

  task automatic wait_acc(input int n, input string name);
    int k;
    for (k = 0; k < 5000; k++) begin
      @(posedge clk);
      if (n_acc >= n) break;
    end
    check(name, int'(k < 5000), 1);
  endtask

  task automatic check_frame(input string name, input int exp_pkt);
    check({name, "_latency"}, first_valid_cyc - strobe_cyc, 4);
    check({name, "_bytes"}, n_acc, PLEN + 1);
    check({name, "_queue"}, q.size(), 0);
    check({name, "_pkt_cnt"}, int'(pkt), exp_pkt);
    check({name, "_busy"}, int'(busy), 0);
  endtask

  initial begin : main
    int k;
    rows[0] = '{100, 0, 253, 1};
    rows[1] = '{30, 0, -1, 2};
    rows[2] = '{100, 1, 253, 3};
    rows[3] = '{50, 2, -1, 4};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_raddr", int'(raddr), 0);
    check("rst_tdata", int'(tdata), 0);
    check("rst_tvalid", int'(tvalid), 0);
    check("rst_tlast", int'(tlast), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_drop", int'(drop), 0);
    check("rst_pkt", int'(pkt), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      rdy_div = 0;
      rdy_pct = rows[i].pct;
      start_frame(rows[i].pat);
      wait_done(1'b0, "row_timeout");
      check_frame("row", rows[i].pkt);
      check("row_overrun", int'(overrun), 0);
      if (rows[i].span >= 0) check("row_gapless", last_cyc - first_acc_cyc, rows[i].span);
    end

    // Overrun and drop-count saturation while a slow frame is in flight.
    rdy_div = 4;
    start_frame(1);
    wait_acc(100, "ovr_wait100");
    #1;
    stb = 1'b1;
    @(posedge clk);
    #1;
    stb = 1'b0;
    check("ovr_flag", int'(overrun), 1);
    check("ovr_drop1", int'(drop), 1);
    check("ovr_busy", int'(busy), 1);
    stb = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    stb = 1'b0;
    check("ovr_drop_sat", int'(drop), 255);
    check("ovr_still_busy", int'(busy), 1);
    wait_done(1'b0, "ovr_timeout");
    check_frame("ovr", 5);
    check("ovr_sticky", int'(overrun), 1);

    // Asynchronous reset mid-frame.
    rdy_div = 0;
    rdy_pct = 100;
    start_frame(2);
    wait_acc(50, "rst_wait50");
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", int'(tvalid), 0);
    check("mid_rst_tlast", int'(tlast), 0);
    check("mid_rst_tdata", int'(tdata), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_overrun", int'(overrun), 0);
    check("mid_rst_drop", int'(drop), 0);
    check("mid_rst_pkt", int'(pkt), 0);
    check("mid_rst_raddr", int'(raddr), 0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start_frame(0);
    wait_done(1'b0, "post_rst_timeout");
    check_frame("post_rst", 1);
    check("post_rst_gapless", last_cyc - first_acc_cyc, 253);

    // Sink stalled at frame start, then released.
    rdy_pct = 0;
    start_frame(1);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (tvalid) break;
    end
    check("stall_valid_rise", int'(k < 50), 1);
    repeat (20) begin
      @(negedge clk);
      check("stall_reads", int'(raddr <= 8'd1), 1);
      check("stall_byte0", int'(tdata), int'(mem[0]));
      check("stall_tvalid", int'(tvalid), 1);
    end
    rdy_pct = 100;
    wait_done(1'b0, "stall_timeout");
    check_frame("stall", 2);
    check("stall_gapless", last_cyc - first_acc_cyc, 253);

    // Short frame without delimiter; back-to-back strobe right after busy falls.
    fill(2);
    for (int r = 0; r < 2; r++) begin
      for (int a = 0; a < PLEN2; a++) q2.push_back('{mem[a], 1'(a == PLEN2 - 1)});
      seen_valid2 = 0;
      if (r == 0) begin
        @(posedge clk);
        #1;
      end
      stb2 = 1'b1;
      strobe_cyc = cyc + 1;
      @(posedge clk);
      #1;
      stb2 = 1'b0;
      check("short_busy", int'(busy2), 1);
      check("short_overrun", int'(overrun2), 0);
      wait_done(1'b1, "short_timeout");
      check("short_latency", first_valid2 - strobe_cyc, 4);
      check("short_bytes", n_acc2, PLEN2 * (r + 1));
      check("short_queue", q2.size(), 0);
      check("short_pkt", int'(pkt2), r + 1);
    end
    check("short_drop", int'(drop2), 0);
    check("short_overrun_end", int'(overrun2), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach the summary (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
